mdu_iterative: RTL

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the M-extension operation code (func3 of an R-type instruction with func7 = 0000001) and produces the result that the single-cycle ALU path cannot.
- The execute stage raises start, stalls the pipeline on busy, and captures result on the done pulse.
- Shift-add multiply and restoring divide run at one bit per cycle.

---
 rtl/mdu_iterative.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle. Divide-by-zero
// and signed-overflow divides are resolved at accept without iterating.
module mdu_iterative #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PROD_W = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q,   state_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [XLEN-1:0]   result_q,  result_d;
    logic [1:0]        op_sel_q,  op_sel_d;     // func3[1:0] of the accepted op
    logic              neg_res_q, neg_res_d;    // product / quotient sign
    logic              neg_rem_q, neg_rem_d;    // remainder sign (dividend sign)
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [XLEN-1:0]   mag_a_q,   mag_a_d;      // multiplicand magnitude
    logic [XLEN-1:0]   mag_b_q,   mag_b_d;      // divisor magnitude
    logic [PROD_W-1:0] prod_q,    prod_d;       // product accumulator / multiplier
    logic [XLEN-1:0]   rem_q,     rem_d;        // partial remainder
    logic [XLEN-1:0]   quo_q,     quo_d;        // dividend shifting out, quotient in

    // Operand preparation signals
    logic            accept;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    // Iteration datapath signals
    logic [XLEN:0]     mul_sum;
    logic [PROD_W-1:0] prod_step;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              last_iter;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    // Decode signedness per op, take magnitudes and detect the special divides
    always_comb begin
        accept      = start && !flush;
        is_div      = func3[2];
        a_signed    = is_div ? !func3[0] : (func3[1:0] != 2'b11);
        b_signed    = is_div ? !func3[0] : !func3[1];
        sign_a      = a_signed && op_a[XLEN-1];
        sign_b      = b_signed && op_b[XLEN-1];
        mag_a       = sign_a ? XLEN'(-op_a) : op_a;
        mag_b       = sign_b ? XLEN'(-op_b) : op_b;
        div_by_zero = is_div && (op_b == '0);
        div_ovf     = is_div && !func3[0] && (op_a == INT_MIN) && (op_b == '1);
        special_res = '0;
        if (div_by_zero) begin
            special_res = func3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_res = func3[1] ? '0 : INT_MIN;
        end
    end

    // One multiply step, one restoring-divide step and the final sign fix-ups
    always_comb begin
        mul_sum   = {1'b0, prod_q[PROD_W-1:XLEN]} + {1'b0, mag_a_q};
        prod_step = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                              : {1'b0, prod_q[PROD_W-1:1]};

        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (!div_diff[XLEN]) begin
            rem_step = div_diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = div_shift[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end

        prod_fix  = neg_res_q ? PROD_W'(-prod_step) : prod_step;
        quo_fix   = neg_res_q ? XLEN'(-quo_step) : quo_step;
        rem_fix   = neg_rem_q ? XLEN'(-rem_step) : rem_step;
        last_iter = (cnt_q == CNT_W'(XLEN - 1));
    end

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        op_sel_d  = op_sel_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_sel_d  = func3[1:0];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    cnt_d     = '0;
                    if (div_by_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        mag_b_d = mag_b;
                        quo_d   = mag_a;
                        rem_d   = '0;
                    end else begin
                        state_d = S_MUL;
                        mag_a_d = mag_a;
                        prod_d  = {{XLEN{1'b0}}, mag_b};
                    end
                end
            end
            S_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = (op_sel_q == 2'b00) ? prod_fix[XLEN-1:0]
                                                   : prod_fix[PROD_W-1:XLEN];
                end
            end
            S_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = op_sel_q[1] ? rem_fix : quo_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: back to IDLE, keep the last delivered result
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            op_sel_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            op_sel_q  <= op_sel_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
        end
    end

endmodule
